// File: rtl/cfg_pkg.sv
// rtl/cfg_pkg.sv - build-wide configuration constants
package cfg_pkg;

  localparam int ENGINES_N = 4;

endpackage

// File: rtl/q_pkg.sv
// rtl/q_pkg.sv - shared types and helpers for the engine scheduler
package q_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } sched_state_t;

  function automatic int popcount(input logic [31:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/q_rr_arb.sv
// rtl/q_rr_arb.sv - combinational round-robin picker: first requester at or after ptr
module q_rr_arb #(
  parameter int N     = 4,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt
);

  logic [PTR_W-1:0] sel;
  logic             hit;

  // Descending scans leave the lowest matching index; the second scan handles wrap.
  always_comb begin
    gnt = '0;
    sel = '0;
    hit = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[k] && (PTR_W'(k) >= ptr)) begin
        sel = PTR_W'(k);
        hit = 1'b1;
      end
    end
    if (!hit) begin
      for (int k = N - 1; k >= 0; k--) begin
        if (req[k]) begin
          sel = PTR_W'(k);
          hit = 1'b1;
        end
      end
    end
    if (hit) gnt[sel] = 1'b1;
  end

endmodule

// File: rtl/q_eng_sched.sv
// rtl/q_eng_sched.sv - round-robin command dispatcher over a pool of engines with flush/drain
module q_eng_sched
  import q_pkg::*;
#(
  parameter int ENGINES_N = cfg_pkg::ENGINES_N,
  parameter int CMD_W     = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cmd_vld,
  output logic                           cmd_rdy,
  input  logic [CMD_W-1:0]               cmd_data,
  input  logic                           flush,
  output logic [ENGINES_N-1:0]           eng_start,
  output logic [CMD_W-1:0]               eng_cmd,
  input  logic [ENGINES_N-1:0]           eng_done,
  output logic [ENGINES_N-1:0]           busy,
  output logic [$clog2(ENGINES_N+1)-1:0] busy_cnt,
  output logic                           drained,
  output logic                           err
);

  localparam int PTR_W = (ENGINES_N > 1) ? $clog2(ENGINES_N) : 1;
  localparam int CNT_W = $clog2(ENGINES_N + 1);

  sched_state_t         state;
  logic [PTR_W-1:0]     ptr;
  logic [PTR_W-1:0]     ptr_nxt;
  logic [ENGINES_N-1:0] gnt;
  logic                 accept;

  q_rr_arb #(
    .N     (ENGINES_N),
    .PTR_W (PTR_W)
  ) u_arb (
    .req (~busy),
    .ptr (ptr),
    .gnt (gnt)
  );

  // Arbitration sees only registered busy, so an engine freed this cycle waits a cycle.
  assign cmd_rdy  = !rst && (state == RUN) && !(&busy);
  assign accept   = cmd_vld && cmd_rdy;
  assign drained  = !rst && (state == DRAIN) && (busy == '0);
  assign busy_cnt = CNT_W'(popcount(32'(busy)));

  always_comb begin
    ptr_nxt = ptr;
    for (int k = 0; k < ENGINES_N; k++) begin
      if (gnt[k]) ptr_nxt = (k == ENGINES_N - 1) ? '0 : PTR_W'(k + 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      ptr       <= '0;
      busy      <= '0;
      eng_start <= '0;
      eng_cmd   <= '0;
      err       <= 1'b0;
    end else begin
      eng_start <= accept ? gnt : '0;
      if (accept) begin
        eng_cmd <= cmd_data;
        ptr     <= ptr_nxt;
      end
      busy <= (busy & ~eng_done) | (accept ? gnt : '0);
      if (|(eng_done & ~busy)) err <= 1'b1;
      case (state)
        RUN:     if (flush) state <= DRAIN;
        DRAIN:   if (busy == '0) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

endmodule
